// File: rtl/apb_pkg.sv
// Shared definitions for the APB interconnect: FSM state encoding and
// error-counter sizing.
package apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP,
      ST_DERR,
      ST_TOUT
   } apb_state_t;

   localparam int ERR_CNT_W = 16;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Index width for a completer count; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Region decoder: compares the address tag above REGION_LOG2 against each
// completer base; the lowest matching index wins on overlap.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int NUM_SLAVES  = 4,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
      {32'h4000, 32'h3000, 32'h2000, 32'h1000},
   parameter int REGION_LOG2 = 12
) (
   input  logic [ADDR_WIDTH-1:0]                addr,
   output logic                                 hit,
   output logic [idx_width(NUM_SLAVES)-1:0]     index
);

   localparam int IDX_W = idx_width(NUM_SLAVES);
   localparam int TAG_W = ADDR_WIDTH - REGION_LOG2;

   always_comb begin
      hit   = 1'b0;
      index = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (!hit && addr[ADDR_WIDTH-1:REGION_LOG2] ==
                     SLAVE_BASE[i*ADDR_WIDTH + REGION_LOG2 +: TAG_W]) begin
            hit   = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/apb_interconnect.sv
// One-requester to NUM_SLAVES-completer APB bridge with decode-error and
// ACCESS-wait timeout responses plus a saturating error counter.
module apb_interconnect
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
      {32'h4000, 32'h3000, 32'h2000, 32'h1000},
   parameter int REGION_LOG2    = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             PCLK,
   input  logic                             PRESET,
   input  logic                             s_psel,
   input  logic                             s_penable,
   input  logic                             s_pwrite,
   input  logic [ADDR_WIDTH-1:0]            s_paddr,
   input  logic [DATA_WIDTH-1:0]            s_pwdata,
   input  logic [DATA_WIDTH/8-1:0]          s_pstrb,
   output logic [DATA_WIDTH-1:0]            s_prdata,
   output logic                             s_pready,
   output logic                             s_pslverr,
   output logic [NUM_SLAVES-1:0]            m_psel,
   output logic                             m_penable,
   output logic                             m_pwrite,
   output logic [ADDR_WIDTH-1:0]            m_paddr,
   output logic [DATA_WIDTH-1:0]            m_pwdata,
   output logic [DATA_WIDTH/8-1:0]          m_pstrb,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata,
   input  logic [NUM_SLAVES-1:0]            m_pready,
   input  logic [NUM_SLAVES-1:0]            m_pslverr,
   output logic [ERR_CNT_W-1:0]             err_count,
   output logic                             decode_err,
   output logic                             timeout_err
);

   localparam int IDX_W = idx_width(NUM_SLAVES);
   localparam logic [31:0] TO_LAST =
      (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

   apb_state_t             state, state_nxt;
   logic                   dec_hit;
   logic [IDX_W-1:0]       dec_idx, idx_q;
   logic [31:0]            wait_cnt;
   logic [DATA_WIDTH-1:0]  rdata_q;
   logic                   rerr_q;
   logic                   req_start;

   assign req_start = (state == ST_IDLE) && s_psel && !s_penable;

   apb_addr_decoder #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .NUM_SLAVES  (NUM_SLAVES),
      .SLAVE_BASE  (SLAVE_BASE),
      .REGION_LOG2 (REGION_LOG2)
   ) u_dec (
      .addr  (s_paddr),
      .hit   (dec_hit),
      .index (dec_idx)
   );

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req_start) state_nxt = dec_hit ? ST_SETUP : ST_DERR;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (m_pready[idx_q])
               state_nxt = ST_RESP;
            else if (TIMEOUT_CYCLES != 0 && wait_cnt == TO_LAST)
               state_nxt = ST_TOUT;
         end
         ST_RESP, ST_DERR, ST_TOUT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      m_psel      = '0;
      m_penable   = 1'b0;
      s_pready    = 1'b0;
      s_pslverr   = 1'b0;
      s_prdata    = '0;
      decode_err  = 1'b0;
      timeout_err = 1'b0;
      case (state)
         ST_SETUP:  m_psel[idx_q] = 1'b1;
         ST_ACCESS: begin
            m_psel[idx_q] = 1'b1;
            m_penable     = 1'b1;
         end
         ST_RESP: begin
            s_pready  = 1'b1;
            s_pslverr = rerr_q;
            s_prdata  = rdata_q;
         end
         ST_DERR: begin
            s_pready   = 1'b1;
            s_pslverr  = 1'b1;
            decode_err = 1'b1;
         end
         ST_TOUT: begin
            s_pready    = 1'b1;
            s_pslverr   = 1'b1;
            timeout_err = 1'b1;
         end
         default: ;
      endcase
   end

   // Request fields are captured once in IDLE so the completer side sees
   // them stable from SETUP through ACCESS.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         idx_q     <= '0;
         m_paddr   <= '0;
         m_pwdata  <= '0;
         m_pwrite  <= 1'b0;
         m_pstrb   <= '0;
         wait_cnt  <= '0;
         rdata_q   <= '0;
         rerr_q    <= 1'b0;
         err_count <= '0;
      end else begin
         if (req_start) begin
            idx_q    <= dec_idx;
            m_paddr  <= s_paddr;
            m_pwdata <= s_pwdata;
            m_pwrite <= s_pwrite;
            m_pstrb  <= s_pstrb;
         end
         if (state == ST_SETUP)
            wait_cnt <= '0;
         if (state == ST_ACCESS) begin
            if (m_pready[idx_q]) begin
               rdata_q <= m_prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
               rerr_q  <= m_pslverr[idx_q];
            end else begin
               wait_cnt <= wait_cnt + 32'd1;
            end
         end
         if ((state == ST_DERR || state == ST_TOUT || (state == ST_RESP && rerr_q))
             && err_count != ERR_CNT_MAX)
            err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_apb_interconnect.sv
// Randomized bench for apb_interconnect: a behavioural completer model plus a
// transaction-level reference for decode, latency, response and error count.
module tb_apb_interconnect;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam int TIMEOUT = 16;
   localparam logic [NS*AW-1:0] BASES_PACKED =
      {32'h4000, 32'h3000, 32'h2000, 32'h1000};
   localparam int NEVER = 1000;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              s_psel, s_penable, s_pwrite;
   logic [AW-1:0]     s_paddr;
   logic [DW-1:0]     s_pwdata;
   logic [DW/8-1:0]   s_pstrb;
   logic [DW-1:0]     s_prdata;
   logic              s_pready, s_pslverr;
   logic [NS-1:0]     m_psel;
   logic              m_penable, m_pwrite;
   logic [AW-1:0]     m_paddr;
   logic [DW-1:0]     m_pwdata;
   logic [DW/8-1:0]   m_pstrb;
   logic [NS*DW-1:0]  m_prdata;
   logic [NS-1:0]     m_pready;
   logic [NS-1:0]     m_pslverr;
   logic [15:0]       err_count;
   logic              decode_err, timeout_err;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned slv_waits = 0;
   int unsigned acc_cnt = 0;
   logic [15:0] err_model = '0;

   apb_interconnect #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .NUM_SLAVES     (NS),
      .SLAVE_BASE     (BASES_PACKED),
      .REGION_LOG2    (12),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .s_psel      (s_psel),
      .s_penable   (s_penable),
      .s_pwrite    (s_pwrite),
      .s_paddr     (s_paddr),
      .s_pwdata    (s_pwdata),
      .s_pstrb     (s_pstrb),
      .s_prdata    (s_prdata),
      .s_pready    (s_pready),
      .s_pslverr   (s_pslverr),
      .m_psel      (m_psel),
      .m_penable   (m_penable),
      .m_pwrite    (m_pwrite),
      .m_paddr     (m_paddr),
      .m_pwdata    (m_pwdata),
      .m_pstrb     (m_pstrb),
      .m_prdata    (m_prdata),
      .m_pready    (m_pready),
      .m_pslverr   (m_pslverr),
      .err_count   (err_count),
      .decode_err  (decode_err),
      .timeout_err (timeout_err)
   );

   always #5 PCLK = ~PCLK;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Selected completer answers after slv_waits ACCESS cycles; unselected
   // completers toggle pready randomly to expose wrong-index use.
   always @(negedge PCLK) begin
      if (m_penable) begin
         m_pready = ((acc_cnt == slv_waits) ? m_psel : '0) | (NS'($urandom) & ~m_psel);
         acc_cnt++;
      end else begin
         m_pready = NS'($urandom) & ~m_psel;
         acc_cnt  = 0;
      end
   end

   function automatic int model_dec(input logic [AW-1:0] addr);
      logic [AW-1:0] base;
      for (int i = 0; i < NS; i++) begin
         base = BASES_PACKED[i*AW +: AW];
         if ((addr >> 12) == (base >> 12)) return i;
      end
      return -1;
   endfunction

   task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                          input int unsigned waits, input logic [DW-1:0] rd_val,
                          input logic [NS-1:0] errs);
      int exp_idx, exp_cyc, cyc;
      logic exp_err, is_tout, got;
      logic [DW-1:0] exp_rd;
      logic [DW/8-1:0] strb;
      logic [NS-1:0] exp_sel;

      exp_idx = model_dec(addr);
      strb = 4'($urandom);
      for (int i = 0; i < NS; i++) m_prdata[i*DW +: DW] = $urandom;
      m_pslverr = errs;
      slv_waits = waits;
      is_tout = 1'b0;
      exp_sel = '0;
      exp_rd  = '0;
      if (exp_idx < 0) begin
         exp_cyc = 1; exp_err = 1'b1;
      end else begin
         m_prdata[exp_idx*DW +: DW] = rd_val;
         exp_sel = NS'(1) << exp_idx;
         if (waits >= TIMEOUT) begin
            exp_cyc = 2 + TIMEOUT; exp_err = 1'b1; is_tout = 1'b1;
         end else begin
            exp_cyc = 3 + waits; exp_err = errs[exp_idx]; exp_rd = rd_val;
         end
      end

      @(negedge PCLK);
      s_psel = 1'b1; s_penable = 1'b0; s_paddr = addr; s_pwrite = wr;
      s_pwdata = wdata; s_pstrb = strb;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 40) begin
         @(negedge PCLK);
         cyc++;
         if (cyc == 1) s_penable = 1'b1;
         check_eq("m_psel", m_psel, (cyc < exp_cyc) ? exp_sel : '0);
         check_eq("m_penable", m_penable, (exp_idx >= 0 && cyc >= 2 && cyc < exp_cyc));
         if (exp_idx >= 0 && cyc < exp_cyc) begin
            check_eq("m_paddr", m_paddr, addr);
            check_eq("m_pwdata", m_pwdata, wdata);
            check_eq("m_pwrite", m_pwrite, wr);
            check_eq("m_pstrb", m_pstrb, strb);
         end
         if (s_pready) begin
            got = 1'b1;
            check_eq("pready_cycle", cyc, exp_cyc);
            check_eq("s_pslverr", s_pslverr, exp_err);
            if (!(wr && exp_idx >= 0 && !is_tout))
               check_eq("s_prdata", s_prdata, exp_rd);
            check_eq("decode_err", decode_err, (exp_idx < 0));
            check_eq("timeout_err", timeout_err, is_tout);
            s_psel = 1'b0; s_penable = 1'b0;
         end else begin
            check_eq("prdata_idle", s_prdata, '0);
         end
      end
      if (!got) begin
         check_eq("pready_seen", 0, 1);
         s_psel = 1'b0; s_penable = 1'b0;
      end
      if (exp_err && err_model != 16'hFFFF) err_model++;
      @(negedge PCLK);
      check_eq("pready_after", s_pready, 0);
      check_eq("err_count", err_count, err_model);
   endtask

   initial begin
      logic [AW-1:0] a;
      int sel;
      PRESET = 1'b1;
      s_psel = 0; s_penable = 0; s_pwrite = 0; s_paddr = '0; s_pwdata = '0; s_pstrb = '0;
      m_prdata = '0; m_pslverr = '0;
      repeat (3) @(negedge PCLK);
      check_eq("rst_m_psel", m_psel, 0);
      check_eq("rst_s_pready", s_pready, 0);
      check_eq("rst_err_count", err_count, 0);
      check_eq("rst_m_paddr", m_paddr, 0);
      PRESET = 1'b0;

      do_xfer(32'h2004, 1'b1, 32'hDEADBEEF, 0, 32'h0, 4'b0000);
      do_xfer(32'h3010, 1'b0, 32'h0, 3, 32'h12345678, 4'b0000);
      do_xfer(32'h9000, 1'b0, 32'h0, 0, 32'h0, 4'b0000);
      do_xfer(32'h1000, 1'b0, 32'h0, NEVER, 32'h0, 4'b0000);
      do_xfer(32'h4ABC, 1'b1, 32'hCAFE0001, 1, 32'h0, 4'b1000);

      // Reset during ACCESS: outputs must drop before the next clock edge.
      slv_waits = NEVER;
      @(negedge PCLK);
      s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h1004; s_pwrite = 1'b1; s_pwdata = 32'h55;
      @(negedge PCLK);
      s_penable = 1'b1;
      @(negedge PCLK);
      check_eq("pre_rst_penable", m_penable, 1);
      #2 PRESET = 1'b1;
      #1;
      check_eq("arst_m_psel", m_psel, 0);
      check_eq("arst_m_penable", m_penable, 0);
      check_eq("arst_m_paddr", m_paddr, 0);
      check_eq("arst_err_count", err_count, 0);
      check_eq("arst_s_pready", s_pready, 0);
      err_model = '0;
      s_psel = 1'b0; s_penable = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      do_xfer(32'h1008, 1'b0, 32'h0, 2, 32'hA5A5F00F, 4'b0000);

      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 4);
         if (sel < NS) a = BASES_PACKED[sel*AW +: AW] + AW'($urandom_range(0, 4095));
         else a = $urandom;
         do_xfer(a, 1'($urandom), $urandom,
                 ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 5),
                 $urandom, NS'($urandom & $urandom));
      end

      // Preload the counter just below saturation, then push it over.
      @(negedge PCLK);
      force dut.err_count = 16'hFFFE;
      #1 release dut.err_count;
      err_model = 16'hFFFE;
      do_xfer(32'h0000_8000, 1'b0, 32'h0, 0, 32'h0, 4'b0000);
      do_xfer(32'hF000_0000, 1'b1, 32'h1, 0, 32'h0, 4'b0000);
      do_xfer(32'h2000, 1'b0, 32'h0, NEVER, 32'h0, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_interconnect.md
APB_INTERCONNECT -- requirements
Module: apb_interconnect

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; PSTRB width is DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, number of completer ports, range 1..16.
REQ-004 SHALL have parameter SLAVE_BASE, default {32'h4000,32'h3000,32'h2000,32'h1000}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slot i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-005 SHALL have parameter REGION_LOG2, default 12, log2 of the region size per slave.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS-wait limit; 0 disables the timeout.
REQ-007 SHALL have port PCLK, input, 1, the single clock; all logic is rising-edge.
REQ-008 SHALL have port PRESET, input, 1, reset, asynchronous and active-high.
REQ-009 SHALL have requester inputs s_psel, s_penable, s_pwrite (1 each), s_paddr (ADDR_WIDTH), s_pwdata (DATA_WIDTH) and s_pstrb (DATA_WIDTH/8).
REQ-010 SHALL have requester outputs s_prdata (DATA_WIDTH), s_pready (1) and s_pslverr (1).
REQ-011 SHALL have completer outputs m_psel (NUM_SLAVES), m_penable, m_pwrite, m_paddr, m_pwdata and m_pstrb, shared by all slaves except m_psel.
REQ-012 SHALL have completer inputs m_prdata (packed NUM_SLAVES*DATA_WIDTH), m_pready (NUM_SLAVES) and m_pslverr (NUM_SLAVES).
REQ-013 SHALL have status outputs err_count (16, saturating), decode_err (1, one-cycle pulse) and timeout_err (1, one-cycle pulse).

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, DERR and TOUT.
REQ-015 IDLE: on s_psel=1 & s_penable=0, SHALL register s_paddr, s_pwdata, s_pwrite, s_pstrb and the decoded index, then go to SETUP on a hit or DERR on a miss; any other input combination is ignored.
REQ-016 Decode: slave i SHALL hit when s_paddr[ADDR_WIDTH-1:REGION_LOG2] equals SLAVE_BASE_i[ADDR_WIDTH-1:REGION_LOG2]; with overlapping regions the lowest index SHALL win.
REQ-017 SETUP: only m_psel[idx] SHALL be 1, with m_penable=0; next state SHALL be ACCESS and the wait counter SHALL clear.
REQ-018 ACCESS: m_psel[idx] and m_penable SHALL be 1; on m_pready[idx]=1, SHALL register m_prdata slot idx and m_pslverr[idx], then go to RESP.
REQ-019 ACCESS without m_pready: the counter SHALL increment; when it reaches TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES≠0, next state SHALL be TOUT.
REQ-020 RESP: for one cycle, s_pready=1, s_prdata=registered data and s_pslverr=registered error; then IDLE.
REQ-021 DERR: for one cycle, s_pready=1, s_pslverr=1, s_prdata=0 and decode_err=1; no m_psel bit asserted; then IDLE.
REQ-022 TOUT: for one cycle, s_pready=1, s_pslverr=1, s_prdata=0 and timeout_err=1; m_psel and m_penable low (transfer abandoned); then IDLE.
REQ-023 s_pready SHALL be 0 in all other states; s_prdata SHALL be 0 whenever s_pready=0.
REQ-024 Latency: best case, the s_pready cycle SHALL be the 4th cycle after the requester SETUP cycle (cycles 0-3).
REQ-025 m_paddr, m_pwdata, m_pwrite and m_pstrb SHALL be driven from registers and stay stable from SETUP through ACCESS.
REQ-026 err_count SHALL increment by 1 in DERR, TOUT, and RESP with s_pslverr=1, and SHALL hold at 16'hFFFF.
REQ-027 Writes with m_pslverr=1 SHALL report the error upstream; read data is don't-care on a write.
REQ-028 At most one m_psel bit SHALL ever be 1 (one-hot or zero).

Reset
REQ-029 PRESET=1 SHALL asynchronously force IDLE and clear the wait counter, err_count, all registered request/response fields, and all outputs to 0.
REQ-030 Reset mid-transfer SHALL drop m_psel/m_penable immediately; no response is issued for the aborted transfer.

Structure
REQ-031 Package apb_pkg SHALL hold the FSM state encoding, the 16-bit error-counter width and its saturation constant.
REQ-032 Address decode SHALL be a sub-module apb_addr_decoder (inputs: address; outputs: hit, index), sharing parameters with the top.

Verification
REQ-033 Write 0xDEADBEEF to 0x2004 with slave1 pready immediate -> m_psel=4'b0010, s_pready in cycle 3, s_pslverr=0.
REQ-034 Read 0x3010 with slave2 pready after 3 waits and m_prdata=0x12345678 -> s_prdata=0x12345678, s_pready in cycle 6.
REQ-035 Access 0x9000 -> no m_psel, DERR response, decode_err pulse, err_count=1.
REQ-036 Slave0 never ready, TIMEOUT_CYCLES=16 -> TOUT after 16 ACCESS cycles, s_pslverr=1, timeout_err pulse, m_psel cleared.
REQ-037 PRESET asserted during ACCESS -> all outputs 0 asynchronously; next transfer completes normally.
REQ-038 Preload err_count to 16'hFFFE via 2 further error transfers -> value holds at 16'hFFFF.
